// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared types and helpers for the instruction fetch stage.
//   if_state_e : fetch FSM state encodings (2 bits)
//   ifid_op_e  : control applied to the IF/ID pipeline register each cycle
//   ZERO_WORD  : NOP bubble / cleared word
//   pc_inc     : next sequential fetch address (32-bit modulo)
//   word_align : clears address bits [1:0]
// ----------------------------------------------------------------------------
package if_stage_pkg;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register between fetch and decode.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears to bubble)
//   op                : HOLD keeps contents, LOAD captures load_pc/load_inst as
//                       a valid instruction, BUBBLE clears inst/valid, keeps pc
//   load_pc/load_inst : values captured on LOAD
//   pc/inst/inst_valid: registered outputs towards decode
// ----------------------------------------------------------------------------
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ifid_op_e    op,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  // IF/ID register update: reset, load, bubble or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= ZERO_WORD;
      inst       <= ZERO_WORD;
      inst_valid <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          pc         <= load_pc;
          inst       <= load_inst;
          inst_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          inst       <= ZERO_WORD;
          inst_valid <= 1'b0;
        end
        IFID_HOLD: begin
          inst_valid <= inst_valid;
        end
        default: begin
          // Unreachable encoding: fail safe by inserting a bubble.
          inst       <= ZERO_WORD;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: owns the PC, issues req/ack fetches to instruction
// memory and loads the IF/ID register consumed by decode. A one-entry holding
// buffer absorbs a decode stall that coincides with a fetch response, and a
// redirect kills wrong-path work (draining an outstanding request if needed).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : decode not accepting; IF/ID must hold
//   redirect_i      : restart fetch at redirect_pc_i (bits [1:0] ignored)
//   imem_req_o      : fetch request (low in HOLD and while rst=1)
//   imem_addr_o     : word-aligned fetch address, stable until ack
//   imem_ack_i      : response valid this cycle
//   imem_rdata_i    : instruction word, valid with imem_ack_i
//   pc_o/inst_o     : IF/ID pc and instruction (32'h0 = NOP bubble)
//   inst_valid_o    : IF/ID holds a real fetched instruction
// ----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  if_state_e   state_r;
  logic [31:0] pc_r;        // fetch address of the current/next request
  logic [31:0] buf_pc_r;    // holding buffer: pc of the parked instruction
  logic [31:0] buf_inst_r;  // holding buffer: parked instruction word
  logic [31:0] pend_pc_r;   // redirect target waiting for the drain to finish
  logic [31:0] tgt_s;
  logic        ack_s;
  ifid_op_e    ifid_op_s;
  logic [31:0] ld_pc_s;
  logic [31:0] ld_inst_s;

  assign tgt_s       = word_align(redirect_pc_i);
  // No request is outstanding in HOLD, so any ack there is spurious.
  assign ack_s       = imem_ack_i & (state_r != IF_HOLD);
  assign imem_req_o  = (state_r != IF_HOLD) & ~rst;
  assign imem_addr_o = pc_r;

  // IF/ID control decode from current state and inputs
  always_comb begin
    ifid_op_s = IFID_HOLD;
    ld_pc_s   = pc_r;
    ld_inst_s = imem_rdata_i;
    if (redirect_i) begin
      // Wrong-path contents are killed even while decode is stalled.
      ifid_op_s = IFID_BUBBLE;
    end else begin
      case (state_r)
        IF_FETCH: begin
          if (ack_s && !stall_i) begin
            ifid_op_s = IFID_LOAD;
          end else if (!ack_s && !stall_i) begin
            ifid_op_s = IFID_BUBBLE;
          end else begin
            ifid_op_s = IFID_HOLD;
          end
        end
        IF_HOLD: begin
          if (!stall_i) begin
            ifid_op_s = IFID_LOAD;
            ld_pc_s   = buf_pc_r;
            ld_inst_s = buf_inst_r;
          end else begin
            ifid_op_s = IFID_HOLD;
          end
        end
        IF_DRAIN: begin
          if (stall_i) begin
            ifid_op_s = IFID_HOLD;
          end else begin
            ifid_op_s = IFID_BUBBLE;
          end
        end
        default: begin
          ifid_op_s = IFID_BUBBLE;
        end
      endcase
    end
  end

  // Fetch FSM: state, fetch pc, holding buffer and pending redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IF_FETCH;
      pc_r       <= word_align(RESET_PC);
      buf_pc_r   <= ZERO_WORD;
      buf_inst_r <= ZERO_WORD;
      pend_pc_r  <= ZERO_WORD;
    end else if (redirect_i) begin
      case (state_r)
        IF_FETCH: begin
          if (ack_s) begin
            pc_r <= tgt_s;
          end else begin
            // Request still in flight: keep its address until it completes.
            pend_pc_r <= tgt_s;
            state_r   <= IF_DRAIN;
          end
        end
        IF_HOLD: begin
          pc_r    <= tgt_s;
          state_r <= IF_FETCH;
        end
        IF_DRAIN: begin
          if (ack_s) begin
            // Drain completes now; the newest target wins.
            pc_r    <= tgt_s;
            state_r <= IF_FETCH;
          end else begin
            pend_pc_r <= tgt_s;
          end
        end
        default: begin
          pc_r    <= tgt_s;
          state_r <= IF_FETCH;
        end
      endcase
    end else begin
      case (state_r)
        IF_FETCH: begin
          if (ack_s && stall_i) begin
            buf_pc_r   <= pc_r;
            buf_inst_r <= imem_rdata_i;
            state_r    <= IF_HOLD;
          end else if (ack_s) begin
            pc_r <= pc_inc(pc_r);
          end else begin
            pc_r <= pc_r;
          end
        end
        IF_HOLD: begin
          if (!stall_i) begin
            pc_r    <= pc_inc(pc_r);
            state_r <= IF_FETCH;
          end else begin
            state_r <= IF_HOLD;
          end
        end
        IF_DRAIN: begin
          if (ack_s) begin
            pc_r    <= pend_pc_r;
            state_r <= IF_FETCH;
          end else begin
            state_r <= IF_DRAIN;
          end
        end
        default: begin
          state_r <= IF_FETCH;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .op         (ifid_op_s),
    .load_pc    (ld_pc_s),
    .load_inst  (ld_inst_s),
    .pc         (pc_o),
    .inst       (inst_o),
    .inst_valid (inst_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Two fetch stages share stimulus: dut_a (RESET_PC=0) is checked through
// address/instruction scoreboards plus directed checks; dut_b
// (RESET_PC=32'hFFFF_FFFC) covers the wrap and reset-mid-drain cases.
// Each has its own memory model with a programmable number of wait states.
// ----------------------------------------------------------------------------
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_en = 1'b1;
  int          ws = 0;
  logic        sb_on = 1'b1;

  logic        req_a, ack_a, valid_a;
  logic [31:0] addr_a, rdata_a, pc_a, inst_a;
  logic        req_b, ack_b, valid_b;
  logic [31:0] addr_b, rdata_b, pc_b, inst_b;
  int          cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  if_stage #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req_a), .imem_addr_o(addr_a),
    .imem_ack_i(ack_a), .imem_rdata_i(rdata_a), .pc_o(pc_a), .inst_o(inst_a),
    .inst_valid_o(valid_a)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req_b), .imem_addr_o(addr_b),
    .imem_ack_i(ack_b), .imem_rdata_i(rdata_b), .pc_o(pc_b), .inst_o(inst_b),
    .inst_valid_o(valid_b)
  );

  // Memory models: ack after ws waiting cycles of a held request
  assign ack_a   = req_a && mem_en && (cnt_a == ws);
  assign rdata_a = ack_a ? inst_of(addr_a) : 32'hDEAD_BEEF;
  assign ack_b   = req_b && mem_en && (cnt_b == ws);
  assign rdata_b = ack_b ? inst_of(addr_b) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst || !req_a || ack_a) cnt_a <= 0; else cnt_a <= cnt_a + 1;
    if (rst || !req_b || ack_b) cnt_b <= 0; else cnt_b <= cnt_b + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every acked request and every instruction decode accepts
  always @(negedge clk) begin
    if (sb_on) begin
      if (req_a === 1'b1 && ack_a === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fetch: got addr %h expected none", addr_a);
        end else begin
          chk("fetch_addr", addr_a, exp_addr_q.pop_front());
        end
      end
      if (valid_a === 1'b1 && stall === 1'b0) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got pc %h expected none", pc_a);
        end else begin
          logic [31:0] e;
          e = exp_pc_q.pop_front();
          chk("ifid_pc", pc_a, e);
          chk("ifid_inst", inst_a, inst_of(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ws_v);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_en = 1'b1; ws = ws_v;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pc", pc_a, 32'h0);
      chk("rst_inst", inst_a, 32'h0);
      chk("rst_valid", {31'h0, valid_a}, 32'h0);
      chk("rst_req", {31'h0, req_a}, 32'h0);
    end
    rst = 1'b0;
  endtask

  task automatic end_test();
    mem_en = 1'b0;
    repeat (3) tick();
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("pc_q_empty", exp_pc_q.size(), 32'd0);
  endtask

  task automatic push_addrs(input logic [31:0] v[$]);
    foreach (v[i]) exp_addr_q.push_back(v[i]);
  endtask

  task automatic push_pcs(input logic [31:0] v[$]);
    foreach (v[i]) exp_pc_q.push_back(v[i]);
  endtask

  initial begin
    // 1: zero-wait streaming after reset
    push_addrs('{32'h0, 32'h4, 32'h8, 32'hC});
    push_pcs('{32'h0, 32'h4, 32'h8, 32'hC});
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stream_req", {31'h0, req_a}, 32'h1);
      chk("stream_addr", addr_a, 32'(k * 4));
      tick();
    end
    end_test();

    // 2: stall while a response arrives at 0x8 -> HOLD
    push_addrs('{32'h0, 32'h4, 32'h8, 32'hC});
    push_pcs('{32'h0, 32'h4, 32'h8, 32'hC});
    do_reset(0);
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      chk("hold_req", {31'h0, req_a}, 32'h0);
      chk("hold_pc", pc_a, 32'h4);
      chk("hold_inst", inst_a, inst_of(32'h4));
      chk("hold_valid", {31'h0, valid_a}, 32'h1);
    end
    tick();
    stall = 1'b0;
    #1 chk("hold_release_req", {31'h0, req_a}, 32'h0);
    tick(); #1;
    chk("after_hold_req", {31'h0, req_a}, 32'h1);
    chk("after_hold_addr", addr_a, 32'hC);
    chk("after_hold_pc", pc_a, 32'h8);
    tick();
    end_test();

    // 3: two wait states -> two bubbles between instructions
    push_addrs('{32'h0, 32'h4, 32'h8});
    push_pcs('{32'h0, 32'h4, 32'h8});
    do_reset(2);
    #1 chk("ws_addr0", addr_a, 32'h0);
    repeat (3) tick();
    #1;
    chk("ws_valid3", {31'h0, valid_a}, 32'h1);
    chk("ws_addr3", addr_a, 32'h4);
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      chk("ws_bubble_valid", {31'h0, valid_a}, 32'h0);
      chk("ws_bubble_inst", inst_a, 32'h0);
      chk("ws_bubble_pc", pc_a, 32'h0);
      chk("ws_addr_stable", addr_a, 32'h4);
    end
    tick(); #1;
    chk("ws_valid6", {31'h0, valid_a}, 32'h1);
    chk("ws_addr6", addr_a, 32'h8);
    repeat (3) tick();
    end_test();

    // 4: redirect to 0x103 while the 0x10 fetch is waiting -> DRAIN
    push_addrs('{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100});
    push_pcs('{32'h0, 32'h4, 32'h8, 32'hC, 32'h100});
    do_reset(0);
    repeat (4) tick();
    ws = 2;
    tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    #1;
    chk("drain_req", {31'h0, req_a}, 32'h1);
    chk("drain_addr", addr_a, 32'h10);
    chk("drain_valid", {31'h0, valid_a}, 32'h0);
    tick(); #1;
    chk("post_drain_addr", addr_a, 32'h100);
    chk("post_drain_valid", {31'h0, valid_a}, 32'h0);
    repeat (3) tick();
    end_test();

    // 5: redirect and stall in the same cycle
    push_addrs('{32'h0, 32'h4, 32'h8, 32'h40, 32'h44});
    push_pcs('{32'h0, 32'h40, 32'h44});
    do_reset(0);
    tick(); tick();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    stall = 1'b0; redirect = 1'b0;
    #1;
    chk("redir_stall_valid", {31'h0, valid_a}, 32'h0);
    chk("redir_stall_inst", inst_a, 32'h0);
    chk("redir_stall_addr", addr_a, 32'h40);
    tick(); #1;
    chk("redir_target_pc", pc_a, 32'h40);
    tick();
    end_test();

    // 6: RESET_PC=0xFFFF_FFFC wraps; reset asserted mid-DRAIN
    sb_on = 1'b0;
    do_reset(0);
    #1;
    chk("wrap_addr0", addr_b, 32'hFFFF_FFFC);
    chk("wrap_req0", {31'h0, req_b}, 32'h1);
    tick(); #1;
    chk("wrap_addr1", addr_b, 32'h0);
    chk("wrap_pc", pc_b, 32'hFFFF_FFFC);
    chk("wrap_inst", inst_b, inst_of(32'hFFFF_FFFC));
    chk("wrap_valid", {31'h0, valid_b}, 32'h1);
    tick();
    ws = 2; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    #1;
    chk("b_drain_req", {31'h0, req_b}, 32'h1);
    chk("b_drain_addr", addr_b, 32'h4);
    chk("b_drain_valid", {31'h0, valid_b}, 32'h0);
    rst = 1'b1;
    #1 chk("b_rst_req", {31'h0, req_b}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("b_rst_req_after", {31'h0, req_b}, 32'h1);
    chk("b_rst_addr", addr_b, 32'hFFFF_FFFC);
    chk("b_rst_pc", pc_b, 32'h0);
    chk("b_rst_inst", inst_b, 32'h0);
    chk("b_rst_valid", {31'h0, valid_b}, 32'h0);
    tick(); #1;
    chk("b_rst_addr_stable", addr_b, 32'hFFFF_FFFC);
    end_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
